// File: rtl/rps_input_conditioner_if.sv
// Signal bundle between the rock/paper/scissors front-end conditioner and
// whatever drives its raw inputs / consumes its validated choice events.
interface rps_input_conditioner_if;
  // Raw inputs: BTNx active-high, P1Ax active-low, all asynchronous to CLK.
  logic       BTN1;
  logic       BTN2;
  logic       BTN3;
  logic       P1A1;
  logic       P1A2;
  logic       P1A3;
  // Conditioned outputs.
  logic [1:0] CHOICE;
  logic       CHOICE_VALID;
  logic       ANY_PRESSED;
  logic       LOCKED;

  // Board / stimulus side: drives the raw inputs, observes the choice.
  modport master (
    output BTN1, BTN2, BTN3, P1A1, P1A2, P1A3,
    input  CHOICE, CHOICE_VALID, ANY_PRESSED, LOCKED
  );

  // Conditioner side.
  modport slave (
    input  BTN1, BTN2, BTN3, P1A1, P1A2, P1A3,
    output CHOICE, CHOICE_VALID, ANY_PRESSED, LOCKED
  );
endinterface

// File: rtl/rps_input_conditioner.sv
// Rock/paper/scissors input conditioner: synchronises and debounces three
// buttons plus three PMOD lines, merges each pair into one channel and emits
// exactly one choice event per press, locking out further presses until every
// channel has been debounced-released.
module rps_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int CNT_W           = 17
) (
  input logic                   CLK,
  input logic                   RESET_N,
  rps_input_conditioner_if.slave io
);

  localparam int NCH = 6;
  // Idle ("released") level per raw line: P1A lines idle high, BTN lines low.
  // Bit order: {P1A3, P1A2, P1A1, BTN3, BTN2, BTN1}.
  localparam logic [NCH-1:0]   REST_LVL = 6'b111_000;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync_p0;
  logic [NCH-1:0] stb_p1;
  logic [2:0]     pressed_p1;

  state_t     state_q, state_d;
  logic [1:0] choice_p2, choice_d;
  logic       choice_vld_p2, choice_vld_d;
  logic       any_p2;

  // Lowest index wins when several channels are pressed together.
  function automatic logic [1:0] encode_choice(input logic [2:0] p);
    if (p[0])      return 2'd1;
    else if (p[1]) return 2'd2;
    else if (p[2]) return 2'd3;
    else           return 2'd0;
  endfunction

  assign raw = {io.P1A3, io.P1A2, io.P1A1, io.BTN3, io.BTN2, io.BTN1};

  // ---- stage p0: synchronisers; stage p1: debounced stable levels ----
  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      logic [SYNC_STAGES-1:0] chain;
      logic [CNT_W-1:0]       cnt;
      logic                   stb;

      // Metastability chain; resets to the line's idle level so no false edge.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) chain <= {SYNC_STAGES{REST_LVL[g]}};
        else          chain <= {chain[SYNC_STAGES-2:0], raw[g]};
      end

      assign sync_p0[g] = chain[SYNC_STAGES-1];

      // Accept a level change only after DEBOUNCE_CYCLES consecutive differing cycles.
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          stb <= REST_LVL[g];
          cnt <= '0;
        end else if (sync_p0[g] == stb) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          stb <= ~stb;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      assign stb_p1[g] = stb;
    end
  endgenerate

  // Button OR inverted PMOD line per channel (0 = rock, 1 = paper, 2 = scissors).
  assign pressed_p1 = stb_p1[2:0] | ~stb_p1[5:3];

  // ---- stage p2: lock-out FSM and registered outputs ----
  // Next-state and choice capture; a choice is only taken from IDLE.
  always_comb begin
    state_d      = state_q;
    choice_d     = choice_p2;
    choice_vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pressed_p1) begin
          state_d      = LOCKED;
          choice_d     = encode_choice(pressed_p1);
          choice_vld_d = 1'b1;
        end
      end
      LOCKED: begin
        if (!(|pressed_p1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, held choice, one-cycle valid pulse and the any-pressed level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      choice_p2     <= 2'd0;
      choice_vld_p2 <= 1'b0;
      any_p2        <= 1'b0;
    end else begin
      state_q       <= state_d;
      choice_p2     <= choice_d;
      choice_vld_p2 <= choice_vld_d;
      any_p2        <= |pressed_p1;
    end
  end

  assign io.CHOICE       = choice_p2;
  assign io.CHOICE_VALID = choice_vld_p2;
  assign io.ANY_PRESSED  = any_p2;
  assign io.LOCKED       = (state_q == LOCKED);

endmodule

// File: tb/tb_rps_input_conditioner.sv
// Directed bench for rps_input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2:
// a table of clean single/multi-channel presses plus hand-written sequences
// for glitching, overlap, release bounce and reset mid-press.
module tb_rps_input_conditioner;

  localparam int LAT = 7;  // SYNC_STAGES + DEBOUNCE_CYCLES + 1

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;

  rps_input_conditioner_if io ();

  rps_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .io     (io)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0] btn;   // {BTN3, BTN2, BTN1}
    logic [2:0] p1a;   // {P1A3, P1A2, P1A1}, active-low
    int         hold;
    int         exp_choice;
  } vec_t;

  vec_t vecs[6];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses;
  int first_pulse;
  int seen_choice;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Advance one clock and sample outputs 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
    if (io.CHOICE_VALID) begin
      pulses++;
      if (first_pulse < 0) begin
        first_pulse = cyc;
        seen_choice = int'(io.CHOICE);
      end
    end
  endtask

  task automatic drive(input logic [2:0] btn, input logic [2:0] p1a);
    io.BTN1 = btn[0];
    io.BTN2 = btn[1];
    io.BTN3 = btn[2];
    io.P1A1 = p1a[0];
    io.P1A2 = p1a[1];
    io.P1A3 = p1a[2];
  endtask

  task automatic clear_events();
    pulses      = 0;
    first_pulse = -1;
    seen_choice = -1;
  endtask

  // Bounded wait for LOCKED to drop; it must drop LAT cycles after rel.
  task automatic wait_unlock(input string name, input int rel);
    int n;
    n = 0;
    while (io.LOCKED && n < 40) begin
      step();
      n++;
    end
    check(name, cyc - rel, LAT);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int rel;

    vecs[0] = '{btn: 3'b010, p1a: 3'b111, hold: 20, exp_choice: 2};  // clean BTN2
    vecs[1] = '{btn: 3'b000, p1a: 3'b110, hold: 12, exp_choice: 1};  // P1A1 low
    vecs[2] = '{btn: 3'b101, p1a: 3'b111, hold: 12, exp_choice: 1};  // BTN1+BTN3 together
    vecs[3] = '{btn: 3'b000, p1a: 3'b011, hold: 12, exp_choice: 3};  // P1A3 low
    vecs[4] = '{btn: 3'b100, p1a: 3'b101, hold: 12, exp_choice: 2};  // BTN3 + P1A2
    vecs[5] = '{btn: 3'b110, p1a: 3'b111, hold: 12, exp_choice: 2};  // BTN2+BTN3

    clear_events();
    drive(3'b000, 3'b111);
    RESET_N = 1'b0;
    repeat (2) step();
    check("rst_choice", int'(io.CHOICE), 0);
    check("rst_valid", int'(io.CHOICE_VALID), 0);
    check("rst_any", int'(io.ANY_PRESSED), 0);
    check("rst_locked", int'(io.LOCKED), 0);
    RESET_N = 1'b1;
    repeat (8) step();
    check("idle_no_pulse", pulses, 0);

    // ---- table-driven clean presses ----
    for (int i = 0; i < 6; i++) begin
      clear_events();
      drive(vecs[i].btn, vecs[i].p1a);
      c0 = cyc;
      repeat (vecs[i].hold) step();
      check($sformatf("v%0d_latency", i), first_pulse - c0, LAT);
      check($sformatf("v%0d_choice", i), seen_choice, vecs[i].exp_choice);
      check($sformatf("v%0d_pulses", i), pulses, 1);
      check($sformatf("v%0d_locked", i), int'(io.LOCKED), 1);
      check($sformatf("v%0d_any", i), int'(io.ANY_PRESSED), 1);
      drive(3'b000, 3'b111);
      rel = cyc;
      wait_unlock($sformatf("v%0d_unlock", i), rel);
      check($sformatf("v%0d_any_rel", i), int'(io.ANY_PRESSED), 0);
      check($sformatf("v%0d_hold_choice", i), int'(io.CHOICE), vecs[i].exp_choice);
      repeat (3) step();
      check($sformatf("v%0d_no_rel_pulse", i), pulses, 1);
    end

    // ---- P1A3 glitching low, then steady low ----
    clear_events();
    for (int k = 0; k < 30; k++) begin
      io.P1A3 = (k % 3 == 2);
      step();
    end
    check("glitch_no_pulse", pulses, 0);
    io.P1A3 = 1'b0;
    c0 = cyc;
    repeat (10) step();
    check("glitch_latency", first_pulse - c0, LAT);
    check("glitch_choice", seen_choice, 3);
    check("glitch_pulses", pulses, 1);
    io.P1A3 = 1'b1;
    rel = cyc;
    wait_unlock("glitch_unlock", rel);
    repeat (3) step();

    // ---- BTN1 held, BTN2 overlaps, BTN1 released first ----
    clear_events();
    io.BTN1 = 1'b1;
    c0 = cyc;
    repeat (10) step();
    io.BTN2 = 1'b1;
    repeat (10) step();
    io.BTN1 = 1'b0;
    repeat (10) step();
    check("ovl_latency", first_pulse - c0, LAT);
    check("ovl_choice", seen_choice, 1);
    check("ovl_still_locked", int'(io.LOCKED), 1);
    io.BTN2 = 1'b0;
    rel = cyc;
    wait_unlock("ovl_unlock", rel);
    check("ovl_pulses", pulses, 1);
    check("ovl_hold_choice", int'(io.CHOICE), 1);
    repeat (3) step();

    // ---- BTN3 release bounce, then a fresh press ----
    clear_events();
    io.BTN3 = 1'b1;
    c0 = cyc;
    repeat (15) step();
    check("bnc_choice", seen_choice, 3);
    io.BTN3 = 1'b0;
    step();
    io.BTN3 = 1'b1;
    step();
    io.BTN3 = 1'b0;
    step();
    io.BTN3 = 1'b1;
    step();
    check("bnc_locked", int'(io.LOCKED), 1);
    io.BTN3 = 1'b0;
    rel = cyc;
    wait_unlock("bnc_unlock", rel);
    repeat (4) step();
    check("bnc_one_pulse", pulses, 1);
    io.BTN3 = 1'b1;
    c0 = cyc;
    repeat (10) step();
    check("bnc_second_pulse", pulses, 2);
    check("bnc_second_choice", int'(io.CHOICE), 3);
    io.BTN3 = 1'b0;
    rel = cyc;
    wait_unlock("bnc_unlock2", rel);
    repeat (3) step();

    // ---- reset pulsed while LOCKED with BTN2 held ----
    clear_events();
    io.BTN2 = 1'b1;
    c0 = cyc;
    repeat (12) step();
    check("rmp_locked", int'(io.LOCKED), 1);
    RESET_N = 1'b0;
    #1;
    check("rmp_choice0", int'(io.CHOICE), 0);
    check("rmp_valid0", int'(io.CHOICE_VALID), 0);
    check("rmp_any0", int'(io.ANY_PRESSED), 0);
    check("rmp_locked0", int'(io.LOCKED), 0);
    repeat (2) step();
    RESET_N = 1'b1;
    clear_events();
    c0 = cyc;
    repeat (12) step();
    check("rmp_latency", first_pulse - c0, LAT);
    check("rmp_choice", seen_choice, 2);
    check("rmp_pulses", pulses, 1);
    io.BTN2 = 1'b0;
    rel = cyc;
    wait_unlock("rmp_unlock", rel);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
